// File: rtl/hazard_ctrl_if.sv
// Bundle between the decode stage and the hazard controller: ID fields and
// EX/MEM status in, pipeline enables, flushes, forwarding selects and counters out.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
) ();
   logic             id_valid_i;
   logic [6:0]       id_opcode_i;
   logic [4:0]       id_rd_i;
   logic [4:0]       id_rs1_i;
   logic [4:0]       id_rs2_i;
   logic             ex_redirect_i;
   logic             mem_stall_i;

   logic             pc_en_o;
   logic             if_id_en_o;
   logic             if_id_flush_o;
   logic             id_ex_en_o;
   logic             id_ex_flush_o;
   logic             pipe_en_o;
   logic [1:0]       fwd_a_sel_o;
   logic [1:0]       fwd_b_sel_o;
   logic [CNT_W-1:0] stall_cnt_o;
   logic [CNT_W-1:0] flush_cnt_o;

   // pipeline side
   modport master (
      output id_valid_i, id_opcode_i, id_rd_i, id_rs1_i, id_rs2_i,
             ex_redirect_i, mem_stall_i,
      input  pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
             pipe_en_o, fwd_a_sel_o, fwd_b_sel_o, stall_cnt_o, flush_cnt_o
   );

   // hazard controller side
   modport slave (
      input  id_valid_i, id_opcode_i, id_rd_i, id_rs1_i, id_rs2_i,
             ex_redirect_i, mem_stall_i,
      output pc_en_o, if_id_en_o, if_id_flush_o, id_ex_en_o, id_ex_flush_o,
             pipe_en_o, fwd_a_sel_o, fwd_b_sel_o, stall_cnt_o, flush_cnt_o
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RISC-V pipeline: load-use stalls, redirect
// flushes, EX operand forwarding and saturating stall/flush counters.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input logic           clk,
   input logic           rst_n,
   hazard_ctrl_if.slave  bus
);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_S    = 7'b0100011;
   localparam logic [6:0] OP_B    = 7'b1100011;
   localparam logic [6:0] OP_J    = 7'b1101111;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_AUIP = 7'b0010111;
   localparam logic [6:0] OP_LOAD = 7'b0000011;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   logic id_uses_rs1;
   logic id_uses_rs2;
   logic id_writes_rd;
   logic id_is_load;

   logic       ex_valid;
   logic       ex_wr;
   logic       ex_load;
   logic [4:0] ex_rd;
   logic [4:0] ex_rs1;
   logic       ex_use1;
   logic [4:0] ex_rs2;
   logic       ex_use2;

   logic       mem_valid;
   logic       mem_wr;
   logic       mem_load;
   logic [4:0] mem_rd;

   // WB results are always forwardable, so its load flag is not kept
   logic       wb_valid;
   logic       wb_wr;
   logic [4:0] wb_rd;

   logic lu;
   logic ex_capture;

   logic pc_en;
   logic if_id_en;
   logic if_id_flush;
   logic id_ex_en;
   logic id_ex_flush;
   logic pipe_en;
   logic [1:0] fwd_a_sel;
   logic [1:0] fwd_b_sel;

   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   always_comb begin
      id_uses_rs1  = 1'b1;
      id_uses_rs2  = 1'b0;
      id_writes_rd = 1'b1;
      id_is_load   = 1'b0;
      if ((bus.id_opcode_i == OP_J) || (bus.id_opcode_i == OP_LUI) ||
          (bus.id_opcode_i == OP_AUIP)) begin
         id_uses_rs1 = 1'b0;
      end
      if ((bus.id_opcode_i == OP_R) || (bus.id_opcode_i == OP_S) ||
          (bus.id_opcode_i == OP_B)) begin
         id_uses_rs2 = 1'b1;
      end
      if ((bus.id_opcode_i == OP_S) || (bus.id_opcode_i == OP_B) ||
          (bus.id_rd_i == 5'd0)) begin
         id_writes_rd = 1'b0;
      end
      if (bus.id_opcode_i == OP_LOAD) begin
         id_is_load = 1'b1;
      end
   end

   always_comb begin
      lu = 1'b0;
      if (bus.id_valid_i && ex_valid && ex_load && ex_wr) begin
         lu = (id_uses_rs1 && (bus.id_rs1_i == ex_rd)) ||
              (id_uses_rs2 && (bus.id_rs2_i == ex_rd));
      end
   end

   // freeze beats redirect beats load-use
   always_comb begin
      pc_en       = 1'b1;
      if_id_en    = 1'b1;
      if_id_flush = 1'b0;
      id_ex_en    = 1'b1;
      id_ex_flush = 1'b0;
      pipe_en     = 1'b1;
      if (bus.mem_stall_i) begin
         pc_en    = 1'b0;
         if_id_en = 1'b0;
         id_ex_en = 1'b0;
         pipe_en  = 1'b0;
      end else if (bus.ex_redirect_i) begin
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (lu) begin
         pc_en       = 1'b0;
         if_id_en    = 1'b0;
         id_ex_flush = 1'b1;
      end
   end

   assign ex_capture = bus.id_valid_i && !bus.ex_redirect_i && !lu;

   // loads in MEM have no data yet; they get picked up from WB a cycle later
   always_comb begin
      fwd_a_sel = FWD_RF;
      if (mem_valid && mem_wr && !mem_load && (mem_rd == ex_rs1) && ex_use1) begin
         fwd_a_sel = FWD_MEM;
      end else if (wb_valid && wb_wr && (wb_rd == ex_rs1) && ex_use1) begin
         fwd_a_sel = FWD_WB;
      end
   end

   always_comb begin
      fwd_b_sel = FWD_RF;
      if (mem_valid && mem_wr && !mem_load && (mem_rd == ex_rs2) && ex_use2) begin
         fwd_b_sel = FWD_MEM;
      end else if (wb_valid && wb_wr && (wb_rd == ex_rs2) && ex_use2) begin
         fwd_b_sel = FWD_WB;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid  <= 1'b0;
         ex_wr     <= 1'b0;
         ex_load   <= 1'b0;
         ex_rd     <= 5'd0;
         ex_rs1    <= 5'd0;
         ex_use1   <= 1'b0;
         ex_rs2    <= 5'd0;
         ex_use2   <= 1'b0;
         mem_valid <= 1'b0;
         mem_wr    <= 1'b0;
         mem_load  <= 1'b0;
         mem_rd    <= 5'd0;
         wb_valid  <= 1'b0;
         wb_wr     <= 1'b0;
         wb_rd     <= 5'd0;
      end else if (!bus.mem_stall_i) begin
         wb_valid  <= mem_valid;
         wb_wr     <= mem_wr;
         wb_rd     <= mem_rd;
         mem_valid <= ex_valid;
         mem_wr    <= ex_wr;
         mem_load  <= ex_load;
         mem_rd    <= ex_rd;
         if (ex_capture) begin
            ex_valid <= 1'b1;
            ex_wr    <= id_writes_rd;
            ex_load  <= id_is_load;
            ex_rd    <= bus.id_rd_i;
            ex_rs1   <= bus.id_rs1_i;
            ex_use1  <= id_uses_rs1;
            ex_rs2   <= bus.id_rs2_i;
            ex_use2  <= id_uses_rs2;
         end else begin
            // a bubble must not request forwarding either
            ex_valid <= 1'b0;
            ex_wr    <= 1'b0;
            ex_load  <= 1'b0;
            ex_rd    <= 5'd0;
            ex_rs1   <= 5'd0;
            ex_use1  <= 1'b0;
            ex_rs2   <= 5'd0;
            ex_use2  <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (!bus.mem_stall_i) begin
         if (bus.ex_redirect_i) begin
            if (flush_cnt != '1) begin
               flush_cnt <= flush_cnt + 1'b1;
            end
         end else if (lu) begin
            if (stall_cnt != '1) begin
               stall_cnt <= stall_cnt + 1'b1;
            end
         end
      end
   end

   assign bus.pc_en_o       = pc_en;
   assign bus.if_id_en_o    = if_id_en;
   assign bus.if_id_flush_o = if_id_flush;
   assign bus.id_ex_en_o    = id_ex_en;
   assign bus.id_ex_flush_o = id_ex_flush;
   assign bus.pipe_en_o     = pipe_en;
   assign bus.fwd_a_sel_o   = fwd_a_sel;
   assign bus.fwd_b_sel_o   = fwd_b_sel;
   assign bus.stall_cnt_o   = stall_cnt;
   assign bus.flush_cnt_o   = flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: the driver pushes hand-computed expectations
// into a queue, a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl;

   localparam int CNT_W = 4;

   localparam logic [6:0] LD = 7'b0000011;
   localparam logic [6:0] RR = 7'b0110011;
   localparam logic [6:0] II = 7'b0010011;
   localparam logic [6:0] SS = 7'b0100011;
   localparam logic [6:0] JJ = 7'b1101111;
   localparam logic [6:0] UU = 7'b0110111;

   // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, pipe_en}
   localparam logic [5:0] NRM = 6'b110101;
   localparam logic [5:0] LUS = 6'b000111;
   localparam logic [5:0] RED = 6'b111111;
   localparam logic [5:0] FRZ = 6'b000000;

   typedef struct {
      logic [5:0] ctl;
      logic [1:0] fa;
      logic [1:0] fb;
      int         sc;
      int         fc;
      int         id;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t q[$];
   int   n_chk;
   int   n_fail;
   int   vec_id;

   hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic v, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic red, input logic ms);
      bus.id_valid_i    = v;
      bus.id_opcode_i   = op;
      bus.id_rd_i       = rd;
      bus.id_rs1_i      = rs1;
      bus.id_rs2_i      = rs2;
      bus.ex_redirect_i = red;
      bus.mem_stall_i   = ms;
   endtask

   task automatic expect_now(input logic [5:0] ctl, input logic [1:0] fa,
                             input logic [1:0] fb, input int sc, input int fc);
      exp_t e;
      e.ctl = ctl;
      e.fa  = fa;
      e.fb  = fb;
      e.sc  = sc;
      e.fc  = fc;
      e.id  = vec_id;
      vec_id++;
      q.push_back(e);
   endtask

   task automatic step(input logic v, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic red, input logic ms,
                       input logic [5:0] ctl, input logic [1:0] fa,
                       input logic [1:0] fb, input int sc, input int fc);
      @(posedge clk);
      #1;
      drive(v, op, rd, rs1, rs2, red, ms);
      expect_now(ctl, fa, fb, sc, fc);
   endtask

   always @(negedge clk) begin : monitor
      exp_t       e;
      logic [5:0] got;
      if (q.size() > 0) begin
         e   = q.pop_front();
         got = {bus.pc_en_o, bus.if_id_en_o, bus.if_id_flush_o,
                bus.id_ex_en_o, bus.id_ex_flush_o, bus.pipe_en_o};
         n_chk++;
         if (got !== e.ctl || bus.fwd_a_sel_o !== e.fa || bus.fwd_b_sel_o !== e.fb ||
             int'(bus.stall_cnt_o) != e.sc || int'(bus.flush_cnt_o) != e.fc) begin
            n_fail++;
            $display("FAIL vec%0d: ctl got %b exp %b, fwd_a got %b exp %b, fwd_b got %b exp %b, stall_cnt got %0d exp %0d, flush_cnt got %0d exp %0d",
                     e.id, got, e.ctl, bus.fwd_a_sel_o, e.fa, bus.fwd_b_sel_o, e.fb,
                     int'(bus.stall_cnt_o), e.sc, int'(bus.flush_cnt_o), e.fc);
         end
      end
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      vec_id = 0;
      rst_n  = 1'b0;
      drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

      // reset state with idle inputs
      step(0, 7'd0, 0, 0, 0, 0, 0, NRM, 2'b00, 2'b00, 0, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // load then dependent R-type
      step(1, LD,  5, 1, 0, 0, 0, NRM, 2'b00, 2'b00, 0, 0);
      step(1, RR,  6, 5, 2, 0, 0, LUS, 2'b00, 2'b00, 0, 0);
      step(1, RR,  6, 5, 2, 0, 0, NRM, 2'b00, 2'b00, 1, 0);
      step(0, 7'd0, 0, 0, 0, 0, 0, NRM, 2'b01, 2'b00, 1, 0);

      // back-to-back ALU, three-apart, rd = 0 producer
      step(1, II,  3, 0, 0, 0, 0, NRM, 2'b00, 2'b00, 1, 0);
      step(1, RR,  8, 4, 3, 0, 0, NRM, 2'b00, 2'b00, 1, 0);
      step(0, 7'd0, 0, 0, 0, 0, 0, NRM, 2'b00, 2'b10, 1, 0);
      step(1, II,  9, 0, 0, 0, 0, NRM, 2'b00, 2'b00, 1, 0);
      step(0, 7'd0, 0, 0, 0, 0, 0, NRM, 2'b00, 2'b00, 1, 0);
      step(1, RR, 10, 9, 9, 0, 0, NRM, 2'b00, 2'b00, 1, 0);
      step(0, 7'd0, 0, 0, 0, 0, 0, NRM, 2'b01, 2'b01, 1, 0);
      step(1, II,  0, 0, 0, 0, 0, NRM, 2'b00, 2'b00, 1, 0);
      step(1, RR, 11, 0, 0, 0, 0, NRM, 2'b00, 2'b00, 1, 0);
      step(0, 7'd0, 0, 0, 0, 0, 0, NRM, 2'b00, 2'b00, 1, 0);

      // store after load, then J / U consumers that must not stall
      step(1, LD,  7, 2, 0, 0, 0, NRM, 2'b00, 2'b00, 1, 0);
      step(1, SS,  0, 2, 7, 0, 0, LUS, 2'b00, 2'b00, 1, 0);
      step(1, SS,  0, 2, 7, 0, 0, NRM, 2'b00, 2'b00, 2, 0);
      step(1, LD,  7, 0, 0, 0, 0, NRM, 2'b00, 2'b01, 2, 0);
      step(1, JJ,  7, 7, 7, 0, 0, NRM, 2'b00, 2'b00, 2, 0);
      step(1, LD,  7, 0, 0, 0, 0, NRM, 2'b00, 2'b00, 2, 0);
      step(1, UU,  7, 7, 7, 0, 0, NRM, 2'b00, 2'b00, 2, 0);
      step(0, 7'd0, 0, 0, 0, 0, 0, NRM, 2'b00, 2'b00, 2, 0);

      // redirect together with load-use
      step(1, LD,  5, 0, 0, 0, 0, NRM, 2'b00, 2'b00, 2, 0);
      step(1, RR,  6, 5, 5, 1, 0, RED, 2'b00, 2'b00, 2, 0);

      // memory freeze over a pending load-use
      step(1, II, 12, 0, 0, 0, 0, NRM, 2'b00, 2'b00, 2, 1);
      step(1, LD,  4, 12, 0, 0, 0, NRM, 2'b00, 2'b00, 2, 1);
      for (int i = 0; i < 3; i++) begin
         step(1, RR, 13, 4, 1, 0, 1, FRZ, 2'b10, 2'b00, 2, 1);
      end
      step(1, RR, 13, 4, 1, 0, 0, LUS, 2'b10, 2'b00, 2, 1);
      step(1, RR, 13, 4, 1, 0, 0, NRM, 2'b00, 2'b00, 3, 1);
      step(0, 7'd0, 0, 0, 0, 0, 0, NRM, 2'b01, 2'b00, 3, 1);

      // 20 more load-use stalls: counter saturates at 15
      for (int g = 0; g < 20; g++) begin
         step(1, LD, 5, 0, 0, 0, 0, NRM, (g == 0) ? 2'b00 : 2'b01, 2'b00,
              (3 + g > 15) ? 15 : 3 + g, 1);
         step(1, RR, 6, 5, 0, 0, 0, LUS, 2'b00, 2'b00,
              (3 + g > 15) ? 15 : 3 + g, 1);
         step(1, RR, 6, 5, 0, 0, 0, NRM, 2'b00, 2'b00,
              (4 + g > 15) ? 15 : 4 + g, 1);
      end

      // asynchronous reset in the middle of a load-use stall
      step(1, LD, 5, 0, 0, 0, 0, NRM, 2'b01, 2'b00, 15, 1);
      @(posedge clk);
      #1;
      drive(1'b1, RR, 5'd6, 5'd5, 5'd0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      expect_now(NRM, 2'b00, 2'b00, 0, 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
      step(1, RR, 6, 5, 0, 0, 0, NRM, 2'b00, 2'b00, 0, 0);
      step(0, 7'd0, 0, 0, 0, 0, 0, NRM, 2'b00, 2'b00, 0, 0);

      @(posedge clk);
      #6;
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage RISC-V core. Sits beside the decode stage and consumes the decoded fields of the instruction in ID (`rs1`, `rs2`, `rd`, opcode). It keeps a registered shadow of the destination-register state of EX, MEM and WB. From that it generates:
- PC and pipeline-register enables;
- load-use stalls and branch/jump flushes;
- forwarding selects for the ALU operands in EX.

It also counts stall and flush cycles for performance readout.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating performance counters.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `id_valid_i`, in, 1: ID holds a real instruction.
- `id_opcode_i`, in, 7: ID opcode.
- `id_rd_i`, in, 5: ID destination register.
- `id_rs1_i`, in, 5: ID source register 1.
- `id_rs2_i`, in, 5: ID source register 2.
- `ex_redirect_i`, in, 1: branch taken or jump resolved in EX this cycle.
- `mem_stall_i`, in, 1: data memory not ready; freeze the whole pipeline.
- `pc_en_o`, out, 1: PC register update enable.
- `if_id_en_o`, out, 1: IF/ID register enable.
- `if_id_flush_o`, out, 1: load a NOP into IF/ID.
- `id_ex_en_o`, out, 1: ID/EX register enable.
- `id_ex_flush_o`, out, 1: load a bubble into ID/EX.
- `pipe_en_o`, out, 1: enable for EX/MEM and MEM/WB.
- `fwd_a_sel_o`, out, 2: EX operand A source. 00 = register file, 01 = WB result, 10 = MEM ALU result.
- `fwd_b_sel_o`, out, 2: EX operand B source, same encoding as `fwd_a_sel_o`.
- `stall_cnt_o`, out, `CNT_W`: number of load-use stall cycles.
- `flush_cnt_o`, out, `CNT_W`: number of redirect flush events.

## Operation
- **Opcode classes** (from `risc_v_pipeline_define.svh`):
  - `R` = 0110011, `S` = 0100011, `B` = 1100011, `J` = 1101111, `U` = 0110111 / 0010111.
  - `LOAD` = 0000011; all other opcodes are I-type.
  - `uses_rs1` = not `J` and not `U`.
  - `uses_rs2` = `R`, `S` or `B`.
  - `writes_rd` = not `S` and not `B`, and `rd` != 0.
  - `is_load` = opcode is `LOAD`.
- **Shadow stages** EX, MEM, WB. Each holds {`valid`, `wr`, `is_load`, `rd`}. EX additionally holds {`rs1`, `use1`, `rs2`, `use2`}.
- **Load-use hazard (`lu`):** `id_valid_i` AND EX.`valid` AND EX.`is_load` AND EX.`wr` AND:
  - (`uses_rs1` and `id_rs1_i` == EX.`rd`), OR
  - (`uses_rs2` and `id_rs2_i` == EX.`rd`).
- **Control priority**, highest first:
  1. `mem_stall_i`: `pc_en_o`, `if_id_en_o`, `id_ex_en_o` and `pipe_en_o` all 0; both flushes 0; shadows hold; counters hold.
  2. `ex_redirect_i`: `if_id_flush_o` = 1 and `id_ex_flush_o` = 1; all enables 1; `lu` is ignored; `flush_cnt_o` += 1.
  3. `lu`: `pc_en_o` = 0, `if_id_en_o` = 0, `id_ex_flush_o` = 1; `id_ex_en_o` and `pipe_en_o` stay 1; `stall_cnt_o` += 1.
  4. Otherwise: all enables 1, all flushes 0.
- **Shadow update** on each clock edge when `mem_stall_i` = 0:
  - WB ← MEM; MEM ← EX.
  - EX ← ID fields if `id_valid_i` and not redirect and not `lu`; otherwise EX ← bubble (`valid` = 0).
- **Forwarding** for operand A (operand B is identical, using `rs2` / `use2`):
  - 10 if MEM.`valid` & MEM.`wr` & !MEM.`is_load` & MEM.`rd` == EX.`rs1` & EX.`use1`;
  - else 01 if WB.`valid` & WB.`wr` & WB.`rd` == EX.`rs1` & EX.`use1`;
  - else 00.
  - MEM has priority over WB. `x0` is never forwarded, because `wr` already excludes `rd` = 0.
- **Counters** saturate at all-ones and never wrap.

## Timing
- Enables, flushes and forwarding selects are combinational from the current inputs and the registered shadows; there is no added latency.
- Shadows and counters are the only state, and they update on the rising edge.
- A load-use stall lasts exactly one cycle. Next cycle the load is in MEM and EX holds a bubble, so `lu` deasserts and the load result is forwarded from WB (01) one cycle later.
- `mem_stall_i` held for N cycles freezes state for N cycles. A `lu` or redirect that is pending under the freeze takes effect in the first unfrozen cycle.
- Redirect and `lu` in the same cycle: the redirect wins and `stall_cnt_o` is not incremented.
- **Reset** (asynchronous, `rst_n` = 0): all shadow `valid` bits = 0 and counters = 0. Outputs with idle inputs: all enables = 1, flushes = 0, forwarding selects = 00. Reset asserted mid-stall clears state immediately.

## Test plan
- **Load then dependent R-type.** ID `lw` x5 (`rd` = 5), then ID `add` with `rs1` = 5 → one cycle of `pc_en_o` = 0, `if_id_en_o` = 0, `id_ex_flush_o` = 1. Next cycle all enables 1. Two cycles after the stall, `fwd_a_sel_o` = 01. `stall_cnt_o` = 1.
- **Back-to-back ALU.** `addi` x3 then `add` with `rs2` = 3 → no stall; `fwd_b_sel_o` = 10 when the `add` is in EX. Three-apart dependency → 01. `rd` = 0 producer → 00.
- **Store after load.** `lw` x7, then `sw` with `rs2` = 7 → stall (`uses_rs2`). A `J` or `U` consumer with field bits equal to 7 → no stall.
- **Redirect with simultaneous load-use.** `ex_redirect_i` = 1 in the same cycle as `lu` → `if_id_flush_o` = 1, `id_ex_flush_o` = 1, `pc_en_o` = 1. `flush_cnt_o` += 1 and `stall_cnt_o` unchanged.
- **Memory freeze.** Assert `mem_stall_i` for 3 cycles during a pending load-use → all enables 0 and forwarding selects unchanged for 3 cycles. The stall cycle then follows, and `stall_cnt_o` increments once.
- **Saturation and reset.** With `CNT_W` = 4, trigger 20 load-use stalls → `stall_cnt_o` = 15. Pulse `rst_n` low asynchronously mid-stall → counters 0 and `pc_en_o` = 1 before the next clock edge.
